// File: rtl/dmux_stream_1_n.sv
// Registered 1-to-N stream demultiplexer with per-channel one-entry output
// registers, broadcast mode and a saturating out-of-range select counter.
module dmux_stream_1_n #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned N_CH      = 8,
  parameter int unsigned SEL_W     = 3,
  parameter bit          ZERO_IDLE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [7:0]               bad_sel_cnt
);

  localparam int unsigned CNT_W = 8;

  logic [N_CH-1:0]             valid_q, valid_d;
  logic [N_CH-1:0][DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic [N_CH-1:0] free;
  logic [N_CH-1:0] hit;
  logic            sel_ok;
  logic            ready_raw;
  logic            accept;

  // Destination decode and acceptance; out_ready -> in_ready is the only comb path.
  always_comb begin
    free = ~valid_q | out_ready;
    hit  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      hit[k] = in_bcast | (32'(in_sel) == k);
    end
    sel_ok = (32'(in_sel) < N_CH);
    if (in_bcast) begin
      ready_raw = &free;
    end else if (sel_ok) begin
      ready_raw = |(free & hit);
    end else begin
      ready_raw = 1'b1;
    end
    in_ready = rst_n & ready_raw;
    accept   = in_valid & in_ready;
  end

  // Per-channel next state: refill wins over drain so a same-cycle swap has no bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (accept && hit[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end else if (valid_q[k] && out_ready[k]) begin
        valid_d[k] = 1'b0;
        if (ZERO_IDLE) begin
          data_d[k] = '0;
        end
      end
    end
    if (accept && !in_bcast && !sel_ok && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign bad_sel_cnt = cnt_q;

endmodule

// File: tb/tb_dmux_stream_1_n.sv
// Self-checking bench for dmux_stream_1_n: an 8-channel instance with a
// per-channel scoreboard and a 6-channel instance for out-of-range selects.
module tb_dmux_stream_1_n;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic        in_bcast, in_valid, in_ready;
  logic [63:0] out_data;
  logic [7:0]  out_valid, out_ready, bad_sel_cnt;

  logic [7:0]  in6_data;
  logic [2:0]  in6_sel;
  logic        in6_bcast, in6_valid, in6_ready;
  logic [47:0] out6_data;
  logic [5:0]  out6_valid, out6_ready;
  logic [7:0]  bad6_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] ch;
    logic [7:0] data;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic       v;
    logic       b;
    logic [2:0] sel;
    logic [7:0] data;
    logic [7:0] rdy;
    logic       exp_rdy;
    logic [7:0] exp_vld;
  } vec_t;

  always #5 clk = ~clk;

  dmux_stream_1_n #(.DATA_W(8), .N_CH(8), .SEL_W(3), .ZERO_IDLE(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .bad_sel_cnt(bad_sel_cnt)
  );

  dmux_stream_1_n #(.DATA_W(8), .N_CH(6), .SEL_W(3), .ZERO_IDLE(1'b1)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(in6_data), .in_sel(in6_sel),
    .in_bcast(in6_bcast), .in_valid(in6_valid), .in_ready(in6_ready),
    .out_data(out6_data), .out_valid(out6_valid), .out_ready(out6_ready),
    .bad_sel_cnt(bad6_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic [2:0] s, input logic [7:0] d);
    in_valid = v;
    in_bcast = b;
    in_sel   = s;
    in_data  = d;
  endtask

  // Scoreboard: pop on each output handshake, push on each input handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 8; k++) begin
        if (out_valid[k]) begin
          if (out_ready[k]) begin
            automatic bit found = 1'b0;
            for (int i = 0; i < sbq.size(); i++) begin
              if (!found && sbq[i].ch == 3'(k)) begin
                found = 1'b1;
                chk($sformatf("sb_data_ch%0d", k), 64'(out_data[k*8 +: 8]), 64'(sbq[i].data));
                sbq.delete(i);
                break;
              end
            end
            if (!found) chk($sformatf("sb_spurious_ch%0d", k), 64'(1), 64'(0));
          end
        end else begin
          chk($sformatf("zero_idle_ch%0d", k), 64'(out_data[k*8 +: 8]), 64'(0));
        end
      end
      if (in_valid && in_ready) begin
        if (in_bcast) begin
          for (int k = 0; k < 8; k++) sbq.push_back('{ch: 3'(k), data: in_data});
        end else begin
          sbq.push_back('{ch: in_sel, data: in_data});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{1'b1, 1'b0, 3'd3, 8'hA5, 8'hFF, 1'b1, 8'h08};
    vecs[1] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 3'd0, 8'h11, 8'hFF, 1'b1, 8'h01};
    vecs[3] = '{1'b1, 1'b0, 3'd7, 8'h22, 8'hFF, 1'b1, 8'h80};
    vecs[4] = '{1'b1, 1'b1, 3'd0, 8'h7E, 8'hFF, 1'b1, 8'hFF};
    vecs[5] = '{1'b1, 1'b0, 3'd2, 8'h33, 8'h00, 1'b0, 8'hFF};
    vecs[6] = '{1'b1, 1'b0, 3'd2, 8'h33, 8'h04, 1'b1, 8'hFF};
    vecs[7] = '{1'b1, 1'b1, 3'd0, 8'h44, 8'hFF, 1'b1, 8'hFF};
    vecs[8] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    out_ready  = 8'hFF;
    in6_valid  = 1'b0; in6_bcast = 1'b0; in6_sel = 3'd0; in6_data = 8'h00;
    out6_ready = 6'h3F;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", out_data, 64'(0));
    chk("rst_bad_cnt", 64'(bad_sel_cnt), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].v, vecs[i].b, vecs[i].sel, vecs[i].data);
      out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_rdy));
      step();
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_vld));
    end

    // Backpressure on ch5 with drain-and-refill in one cycle.
    out_ready = 8'hDF;
    drive(1'b1, 1'b0, 3'd5, 8'h11);
    #1 chk("bp_first_ready", 64'(in_ready), 64'(1));
    step();
    drive(1'b1, 1'b0, 3'd5, 8'h22);
    #1 chk("bp_second_ready", 64'(in_ready), 64'(0));
    chk("bp_valid", 64'(out_valid), 64'(8'h20));
    chk("bp_hold_data", 64'(out_data[40 +: 8]), 64'(8'h11));
    step();
    chk("bp_still_valid", 64'(out_valid), 64'(8'h20));
    chk("bp_still_data", 64'(out_data[40 +: 8]), 64'(8'h11));
    out_ready = 8'hFF;
    #1 chk("bp_release_ready", 64'(in_ready), 64'(1));
    step();
    drive(1'b0, 1'b0, 3'd5, 8'h00);
    chk("bp_nogap_valid", 64'(out_valid), 64'(8'h20));
    chk("bp_refill_data", 64'(out_data[40 +: 8]), 64'(8'h22));
    step();
    chk("bp_empty", 64'(out_valid), 64'(0));

    // Stalled ch2 does not block streaming to ch6.
    out_ready = 8'hFB;
    drive(1'b1, 1'b0, 3'd2, 8'h55);
    step();
    chk("ind_ch2_full", 64'(out_valid), 64'(8'h04));
    for (int w = 1; w <= 4; w++) begin
      drive(1'b1, 1'b0, 3'd6, 8'(w));
      #1 chk($sformatf("ind_ready%0d", w), 64'(in_ready), 64'(1));
      step();
      chk($sformatf("ind_valid%0d", w), 64'(out_valid), 64'(8'h44));
      chk($sformatf("ind_ch6_%0d", w), 64'(out_data[48 +: 8]), 64'(w));
      chk($sformatf("ind_ch2_%0d", w), 64'(out_data[16 +: 8]), 64'(8'h55));
    end
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    step();
    chk("ind_after", 64'(out_valid), 64'(8'h04));

    // Broadcast waits for a stalled ch0, then delivers to all channels at once.
    out_ready = 8'hFE;
    drive(1'b1, 1'b0, 3'd0, 8'h66);
    step();
    chk("bc_ch0_full", 64'(out_valid), 64'(8'h01));
    drive(1'b1, 1'b1, 3'd3, 8'h7E);
    #1 chk("bc_blocked_ready", 64'(in_ready), 64'(0));
    step();
    chk("bc_blocked_valid", 64'(out_valid), 64'(8'h01));
    chk("bc_blocked_ch0", 64'(out_data[7:0]), 64'(8'h66));
    out_ready = 8'hFF;
    #1 chk("bc_release_ready", 64'(in_ready), 64'(1));
    step();
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    chk("bc_all_valid", 64'(out_valid), 64'(8'hFF));
    chk("bc_all_data", out_data, 64'h7E7E7E7E7E7E7E7E);
    step();
    chk("bc_drained", 64'(out_valid), 64'(0));

    // Out-of-range selects on the 6-channel instance.
    in6_valid = 1'b1; in6_sel = 3'd6; in6_data = 8'hE1;
    #1 chk("bad_ready_6", 64'(in6_ready), 64'(1));
    step();
    chk("bad_cnt_1", 64'(bad6_cnt), 64'(1));
    chk("bad_novalid_1", 64'(out6_valid), 64'(0));
    in6_sel = 3'd7;
    #1 chk("bad_ready_7", 64'(in6_ready), 64'(1));
    step();
    chk("bad_cnt_2", 64'(bad6_cnt), 64'(2));
    for (int i = 0; i < 300; i++) begin
      in6_sel  = 3'(6 + (i % 2));
      in6_data = 8'(i);
      #1 chk("bad_ready_loop", 64'(in6_ready), 64'(1));
      step();
      chk("bad_novalid_loop", 64'(out6_valid), 64'(0));
    end
    chk("bad_cnt_sat", 64'(bad6_cnt), 64'(255));
    in6_sel = 3'd5; in6_data = 8'hC3;
    step();
    in6_valid = 1'b0;
    chk("n6_ch5_valid", 64'(out6_valid), 64'(6'h20));
    chk("n6_ch5_data", 64'(out6_data[40 +: 8]), 64'(8'hC3));
    chk("n6_cnt_kept", 64'(bad6_cnt), 64'(255));
    step();
    chk("n6_drained", 64'(out6_valid), 64'(0));

    // Asynchronous reset while ch1 and ch4 hold undelivered words.
    out_ready = 8'hED;
    drive(1'b1, 1'b0, 3'd1, 8'h9A);
    step();
    drive(1'b1, 1'b0, 3'd4, 8'hBC);
    step();
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    chk("mid_full", 64'(out_valid), 64'(8'h12));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_data", out_data, 64'(0));
    chk("mid_rst_cnt6", 64'(bad6_cnt), 64'(0));
    chk("mid_rst_ready", 64'(in_ready), 64'(0));
    sbq.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 8'hFF;
    drive(1'b1, 1'b0, 3'd1, 8'h5D);
    #1 chk("post_rst_ready", 64'(in_ready), 64'(1));
    step();
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    chk("post_rst_valid", 64'(out_valid), 64'(8'h02));
    chk("post_rst_data", 64'(out_data[8 +: 8]), 64'(8'h5D));
    step();
    chk("post_rst_empty", 64'(out_valid), 64'(0));

    step();
    step();
    chk("sb_drained", 64'(sbq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
